// File: rtl/lsu_mem_master_if.sv
// Request, response and data-memory signals of the load/store unit.
// The master view belongs to the LSU; the slave view is the environment
// (requester plus word-wide data memory).
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_func3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_write, mem_addr, mem_wdata, mem_func3
    );

    modport slave (
        output req_valid, req_write, req_func3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_write, mem_addr, mem_wdata, mem_func3
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: turns RV32 byte/half/word accesses at any
// alignment into word-only memory reads and read-modify-write stores,
// splitting accesses that straddle a word boundary into two words.
module lsu_mem_master (
    input  logic              clk,
    input  logic              reset_n,
    lsu_mem_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        RESP = 3'd5
    } state_t;

    state_t      state_reg;

    // Captured request fields and fetched memory words
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        write_reg;
    logic [2:0]  func3_reg;
    logic [31:0] word0_reg;
    logic [31:0] word1_reg;

    // Registered outputs
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;
    logic        mem_write_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;

    // Derived access geometry
    logic [1:0]  offset;
    logic [2:0]  size_bytes;
    logic [3:0]  size_nibble;
    logic        crossing;
    logic [31:0] base_addr;
    logic [31:0] next_addr;
    logic        req_legal;

    // Data path
    logic [31:0] word0_cur;
    logic [31:0] word1_cur;
    logic [63:0] window;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic [7:0]  byte_mask;
    logic [63:0] bit_mask;
    logic [63:0] wdata_shift;
    logic [63:0] merged;

    assign offset    = addr_reg[1:0];
    assign base_addr = {addr_reg[31:2], 2'b00};
    // Second word address wraps naturally at 2^32
    assign next_addr = base_addr + 32'd4;

    // Access size from the low func3 bits (00 byte, 01 half, 1x word)
    always_comb begin
        size_bytes  = 3'd4;
        size_nibble = 4'b1111;
        case (func3_reg[1:0])
            2'b00: begin
                size_bytes  = 3'd1;
                size_nibble = 4'b0001;
            end
            2'b01: begin
                size_bytes  = 3'd2;
                size_nibble = 4'b0011;
            end
            default: begin
                size_bytes  = 3'd4;
                size_nibble = 4'b1111;
            end
        endcase
    end

    assign crossing = (({1'b0, offset}) + size_bytes) > 3'd4;

    // Legality of the incoming request: stores only B/H/W, loads also BU/HU
    always_comb begin
        req_legal = 1'b0;
        if (bus.req_write) begin
            req_legal = (bus.req_func3 == 3'b000) || (bus.req_func3 == 3'b001) ||
                        (bus.req_func3 == 3'b010);
        end else begin
            req_legal = (bus.req_func3 == 3'b000) || (bus.req_func3 == 3'b001) ||
                        (bus.req_func3 == 3'b010) || (bus.req_func3 == 3'b100) ||
                        (bus.req_func3 == 3'b101);
        end
    end

    // The word being read this cycle comes straight from memory so the result
    // or merge can be registered on the same edge that captures it.
    assign word0_cur = (state_reg == RD0) ? bus.mem_rdata : word0_reg;
    assign word1_cur = (state_reg == RD1) ? bus.mem_rdata : word1_reg;
    assign window    = {word1_cur, word0_cur};

    // Little-endian extraction of the addressed bytes
    assign load_word = 32'(window >> {offset, 3'b000});

    // Truncate to the access size, then sign- or zero-extend
    always_comb begin
        load_data = load_word;
        case (func3_reg)
            3'b000:  load_data = {{24{load_word[7]}},  load_word[7:0]};
            3'b001:  load_data = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_data = {24'd0, load_word[7:0]};
            3'b101:  load_data = {16'd0, load_word[15:0]};
            default: load_data = load_word;
        endcase
    end

    // Store merge: only the addressed bytes of the two-word window change
    assign byte_mask   = {4'b0000, size_nibble} << offset;
    assign wdata_shift = {32'd0, wdata_reg} << {offset, 3'b000};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_mask
            assign bit_mask[gi*8 +: 8] = {8{byte_mask[gi]}};
        end
    endgenerate

    assign merged = (window & ~bit_mask) | (wdata_shift & bit_mask);

    // Access sequencer with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            write_reg      <= 1'b0;
            func3_reg      <= 3'd0;
            word0_reg      <= 32'd0;
            word1_reg      <= 32'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        addr_reg      <= bus.req_addr;
                        wdata_reg     <= bus.req_wdata;
                        write_reg     <= bus.req_write;
                        func3_reg     <= bus.req_func3;
                        word0_reg     <= 32'd0;
                        word1_reg     <= 32'd0;
                        req_ready_reg <= 1'b0;
                        if (req_legal) begin
                            state_reg    <= RD0;
                            mem_addr_reg <= {bus.req_addr[31:2], 2'b00};
                        end else begin
                            // Illegal width: answer immediately, touch no memory
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'd0;
                        end
                    end
                end

                RD0: begin
                    word0_reg <= bus.mem_rdata;
                    if (crossing) begin
                        state_reg    <= RD1;
                        mem_addr_reg <= next_addr;
                    end else if (write_reg) begin
                        state_reg     <= WR0;
                        mem_write_reg <= 1'b1;
                        mem_addr_reg  <= base_addr;
                        mem_wdata_reg <= merged[31:0];
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_data;
                        mem_addr_reg   <= 32'd0;
                    end
                end

                RD1: begin
                    word1_reg <= bus.mem_rdata;
                    if (write_reg) begin
                        state_reg     <= WR0;
                        mem_write_reg <= 1'b1;
                        mem_addr_reg  <= base_addr;
                        mem_wdata_reg <= merged[31:0];
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_data;
                        mem_addr_reg   <= 32'd0;
                    end
                end

                WR0: begin
                    if (crossing) begin
                        state_reg     <= WR1;
                        mem_write_reg <= 1'b1;
                        mem_addr_reg  <= next_addr;
                        mem_wdata_reg <= merged[63:32];
                    end else begin
                        state_reg      <= RESP;
                        mem_write_reg  <= 1'b0;
                        mem_addr_reg   <= 32'd0;
                        mem_wdata_reg  <= 32'd0;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= 32'd0;
                    end
                end

                WR1: begin
                    state_reg      <= RESP;
                    mem_write_reg  <= 1'b0;
                    mem_addr_reg   <= 32'd0;
                    mem_wdata_reg  <= 32'd0;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= 32'd0;
                end

                RESP: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'd0;
                    req_ready_reg  <= 1'b1;
                end

                default: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'd0;
                    mem_write_reg  <= 1'b0;
                    mem_addr_reg   <= 32'd0;
                    mem_wdata_reg  <= 32'd0;
                    req_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.mem_write  = mem_write_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.mem_func3  = 3'b010;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a 16-word memory model (address bits
// [5:2]) answers reads combinationally and commits writes on the clock edge.
module tb_lsu_mem_master;

    logic clk;
    logic reset_n;

    lsu_mem_master_if bus ();

    lsu_mem_master dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_data = 32'd0;
    int          wr_count = 0;
    int          resp_count = 0;
    logic [31:0] trace [12];

    int n_checks = 0;
    int n_fail = 0;

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    // Memory model: DUT writes, bench preloads, and event counters
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
        if (bus.resp_valid) resp_count <= resp_count + 1;
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // One handshake; latency counted so the acceptance-edge sample is 1
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic err, output logic tail);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_func3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 99; rdata = 32'd0; err = 1'b0; tail = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            trace[n-1] = bus.mem_addr;
            if (bus.resp_valid) begin
                lat = n; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 99) begin
            @(posedge clk); #1;
            tail = bus.resp_valid | bus.resp_err | (|bus.resp_rdata);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_func3 = 3'b010;
        bus.req_addr = 32'h4; bus.req_wdata = 32'h12345678;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.mem_write !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: mem_write=%b resp_valid=%b req_ready=%b, want 0 0 1",
                     bus.mem_write, bus.resp_valid, bus.req_ready);
        end
        n_checks++;
        if (bus.mem_func3 !== 3'b010 || bus.mem_addr !== 32'd0 || bus.resp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus: mem_func3=%b mem_addr=%h resp_rdata=%h, want 010 0 0",
                     bus.mem_func3, bus.mem_addr, bus.resp_rdata);
        end
        bus.req_valid = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (wr_count !== 0 || resp_count !== 0 || bus.mem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: writes=%0d resps=%0d mem_addr=%h, want 0 0 0",
                     wr_count, resp_count, bus.mem_addr);
        end
        $display("reset: done");
    endtask

    task automatic test_aligned_load();
        int lat; logic [31:0] rd; logic err; logic tail;
        preload(4'd1, 32'hFF00FF00);
        issue(1'b0, 3'b010, 32'h04, 32'd0, lat, rd, err, tail);
        $display("LW @04: rdata=%h lat=%0d err=%b", rd, lat, err);
        n_checks++;
        if (rd !== 32'hFF00FF00 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_data: got %h err %b, want ff00ff00 err 0", rd, err);
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL lw_latency: got %0d, want 2", lat);
        end
        n_checks++;
        if (tail !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_single_pulse: response still active next cycle, want idle");
        end
    endtask

    task automatic test_byte_loads();
        int lat; logic [31:0] rd; logic err; logic tail;
        preload(4'd5, 32'hABCDEDEF);
        issue(1'b0, 3'b000, 32'h15, 32'd0, lat, rd, err, tail);
        $display("LB @15: rdata=%h lat=%0d", rd, lat);
        n_checks++;
        if (rd !== 32'hFFFFFFED || lat !== 2) begin
            n_fail++;
            $display("FAIL lb: got %h lat %0d, want ffffffed lat 2", rd, lat);
        end
        issue(1'b0, 3'b100, 32'h15, 32'd0, lat, rd, err, tail);
        $display("LBU @15: rdata=%h lat=%0d", rd, lat);
        n_checks++;
        if (rd !== 32'h000000ED || lat !== 2) begin
            n_fail++;
            $display("FAIL lbu: got %h lat %0d, want 000000ed lat 2", rd, lat);
        end
        issue(1'b0, 3'b001, 32'h16, 32'd0, lat, rd, err, tail);
        $display("LH @16: rdata=%h lat=%0d", rd, lat);
        n_checks++;
        if (rd !== 32'hFFFFABCD || lat !== 2) begin
            n_fail++;
            $display("FAIL lh: got %h lat %0d, want ffffabcd lat 2", rd, lat);
        end
    endtask

    task automatic test_crossing_store();
        int lat; logic [31:0] rd; logic err; logic tail; int w0;
        preload(4'd3, 32'hAAAAAAAA);
        preload(4'd4, 32'hBBBBBBBB);
        w0 = wr_count;
        issue(1'b1, 3'b010, 32'h0E, 32'h11223344, lat, rd, err, tail);
        $display("SW @0E: mem0C=%h mem10=%h lat=%0d", mem[3], mem[4], lat);
        n_checks++;
        if (mem[3] !== 32'h3344AAAA || mem[4] !== 32'hBBBB1122) begin
            n_fail++;
            $display("FAIL sw_cross_merge: got %h %h, want 3344aaaa bbbb1122", mem[3], mem[4]);
        end
        n_checks++;
        if (lat !== 5 || rd !== 32'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_cross_resp: lat %0d rdata %h err %b, want 5 0 0", lat, rd, err);
        end
        n_checks++;
        if (wr_count - w0 !== 2) begin
            n_fail++;
            $display("FAIL sw_cross_writes: got %0d writes, want 2", wr_count - w0);
        end
    endtask

    task automatic test_crossing_load();
        int lat; logic [31:0] rd; logic err; logic tail;
        issue(1'b0, 3'b101, 32'h13, 32'd0, lat, rd, err, tail);
        $display("LHU @13: rdata=%h lat=%0d", rd, lat);
        n_checks++;
        if (rd !== 32'h0000EFBB || lat !== 3) begin
            n_fail++;
            $display("FAIL lhu_cross: got %h lat %0d, want 0000efbb lat 3", rd, lat);
        end
    endtask

    task automatic test_aligned_store();
        int lat; logic [31:0] rd; logic err; logic tail; int w0;
        preload(4'd2, 32'h11111111);
        w0 = wr_count;
        issue(1'b1, 3'b000, 32'h09, 32'hDEADBEA5, lat, rd, err, tail);
        $display("SB @09: mem08=%h lat=%0d", mem[2], lat);
        n_checks++;
        if (mem[2] !== 32'h1111A511 || lat !== 3 || wr_count - w0 !== 1) begin
            n_fail++;
            $display("FAIL sb: got %h lat %0d writes %0d, want 1111a511 lat 3 writes 1",
                     mem[2], lat, wr_count - w0);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic err; logic tail; int w0;
        w0 = wr_count;
        issue(1'b0, 3'b011, 32'h08, 32'd0, lat, rd, err, tail);
        $display("LD011 @08: err=%b rdata=%h lat=%0d", err, rd, lat);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            n_fail++;
            $display("FAIL illegal_load: err %b rdata %h lat %0d, want 1 0 1", err, rd, lat);
        end
        issue(1'b1, 3'b100, 32'h08, 32'hFFFFFFFF, lat, rd, err, tail);
        $display("ST100 @08: err=%b lat=%0d", err, lat);
        n_checks++;
        if (err !== 1'b1 || lat !== 1 || tail !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_store: err %b lat %0d tail %b, want 1 1 0", err, lat, tail);
        end
        n_checks++;
        if (wr_count - w0 !== 0 || mem[2] !== 32'h1111A511) begin
            n_fail++;
            $display("FAIL illegal_no_write: writes %0d mem08 %h, want 0 1111a511",
                     wr_count - w0, mem[2]);
        end
    endtask

    task automatic test_wrap_load();
        int lat; logic [31:0] rd; logic err; logic tail;
        preload(4'd15, 32'h12345678);
        preload(4'd0, 32'h9ABCDEF0);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, lat, rd, err, tail);
        $display("LW @fffffffe: rdata=%h lat=%0d addr0=%h addr1=%h", rd, lat, trace[0], trace[1]);
        n_checks++;
        if (trace[0] !== 32'hFFFFFFFC || trace[1] !== 32'h00000000) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h %h, want fffffffc 00000000", trace[0], trace[1]);
        end
        n_checks++;
        if (rd !== 32'hDEF01234 || lat !== 3) begin
            n_fail++;
            $display("FAIL wrap_data: got %h lat %0d, want def01234 lat 3", rd, lat);
        end
    endtask

    task automatic test_abort();
        int w0; int r0;
        preload(4'd3, 32'hAAAAAAAA);
        preload(4'd4, 32'hBBBBBBBB);
        w0 = wr_count; r0 = resp_count;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_func3 = 3'b010;
        bus.req_addr = 32'h0E; bus.req_wdata = 32'h55667788;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL abort_in_wr1: mem_write %b mem_addr %h, want 1 00000010",
                     bus.mem_write, bus.mem_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_async: mem_write %b req_ready %b, want 0 1",
                     bus.mem_write, bus.req_ready);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("abort: mem0C=%h mem10=%h writes=%0d resps=%0d",
                 mem[3], mem[4], wr_count - w0, resp_count - r0);
        n_checks++;
        if (resp_count - r0 !== 0 || wr_count - w0 !== 1) begin
            n_fail++;
            $display("FAIL abort_no_resp: resps %0d writes %0d, want 0 1",
                     resp_count - r0, wr_count - w0);
        end
        n_checks++;
        if (mem[3] !== 32'h7788AAAA || mem[4] !== 32'hBBBBBBBB) begin
            n_fail++;
            $display("FAIL abort_mem: got %h %h, want 7788aaaa bbbbbbbb", mem[3], mem[4]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_func3 = 3'b000;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        test_reset();
        test_aligned_load();
        test_byte_loads();
        test_crossing_store();
        test_crossing_load();
        test_aligned_store();
        test_illegal();
        test_wrap_load();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; no parameters.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  load/store request present.
REQ-005 req_ready  output  1  high exactly when FSM is IDLE.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_func3  input  3  RV32 width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 req_addr  input  32  byte address; any alignment.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result; 0 for stores and errors.
REQ-012 resp_err  output  1  illegal func3; valid with resp_valid.
REQ-013 mem_write  output  1  data memory write strobe.
REQ-014 mem_addr  output  32  word-aligned memory address (bits[1:0]=00).
REQ-015 mem_wdata  output  32  full word to write.
REQ-016 mem_func3  output  3  constant 3'b010; only word accesses issued.
REQ-017 mem_rdata  input  32  memory read data, combinational on mem_addr in the same cycle.

Function
REQ-018 Request SHALL be accepted on the edge where req_valid and req_ready are both high; all request fields are captured then.
REQ-019 FSM states: IDLE, RD0, RD1, WR0, WR1, RESP.
REQ-020 IDLE: legal func3 -> RD0; illegal (load 011/110/111, store anything but 000/001/010) -> RESP with error; no memory access.
REQ-021 RD0: mem_addr={addr[31:2],2'b00}; word0 captured from mem_rdata. Next: RD1 if offset+size>4, else WR0 for store, RESP for load.
REQ-022 RD1: mem_addr=word0 address+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); word1 captured. Next: WR0 for store, RESP for load.
REQ-023 WR0: mem_write=1, mem_wdata=word0 with addressed bytes replaced; next WR1 if crossing, else RESP.
REQ-024 WR1: mem_write=1 at word1 address, mem_wdata=word1 with the remaining bytes replaced; next RESP.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then IDLE; no response backpressure.
REQ-026 Byte order little-endian: load data = ({word1,word0} >> 8*addr[1:0]), truncated to size, then sign-extended (000,001) or zero-extended (100,101).
REQ-027 Store merge: store bytes placed at 8*addr[1:0] in {word1,word0}; all other bytes preserved exactly.
REQ-028 Latency (resp_valid high N cycles after acceptance edge): error 1; aligned load 2; crossing load 3; aligned store 3; crossing store 5.
REQ-029 In IDLE and RESP: mem_write=0, mem_addr=0, mem_wdata=0; mem_write SHALL never be high outside WR0/WR1.
REQ-030 resp_rdata and resp_err SHALL be 0 whenever resp_valid is 0.
REQ-031 req_valid while busy SHALL be ignored; the requester holds it until req_ready.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, clear word0/word1 and captured fields, and set all outputs to 0 except req_ready=1 and mem_func3=010.
REQ-033 No request is accepted while reset_n is low.
REQ-034 Reset during any state SHALL abort the operation: no further mem_write and no resp_valid for it. A completed WR0 of a crossing store stays written.

Verification
REQ-035 Reset: reset_n=0 with req_valid=1 -> mem_write=0, resp_valid=0, req_ready=1; no access after release until a new handshake.
REQ-036 Aligned LW: mem[0x04]=0xFF00FF00, load 010 @0x04 -> resp_rdata=0xFF00FF00, resp_valid 2 cycles after accept.
REQ-037 Byte loads: mem[0x14]=0xABCDEDEF; LB @0x15 -> 0xFFFFFFED; LBU @0x15 -> 0x000000ED; LH @0x16 -> 0xFFFFABCD.
REQ-038 Crossing SW: mem[0x0C]=0xAAAAAAAA, mem[0x10]=0xBBBBBBBB, SW 0x11223344 @0x0E -> mem[0x0C]=0x3344AAAA, mem[0x10]=0xBBBB1122; resp_valid 5 cycles after accept.
REQ-039 Illegal: load func3=011 @0x08 -> resp_err=1, resp_rdata=0, 1 cycle after accept; mem_write never high.
REQ-040 Wrap plus abort: LW @0xFFFFFFFE reads 0xFFFFFFFC then 0x00000000; crossing store reset in WR1 -> mem_write drops asynchronously, no resp_valid.
